// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: moves a W-bit operand by a runtime amount, at most
// STEP positions per clock, with ready/valid on both sides and carry/zero flags.
module seq_shifter #(
  parameter int W    = 16,
  parameter int STEP = 4,
  parameter int AW   = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_carry,
  output logic          out_zero
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [AW-1:0] STEP_A  = AW'(STEP);
  localparam logic [AW-1:0] AMT_MAX = AW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic          carry_q, carry_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [2:0]    op_q, op_d;

  logic [AW-1:0] amt_sat;
  logic [AW-1:0] s_step;
  logic          is_shift_op;
  logic [W:0]    step_res;

  // One step of s (1..STEP) positions; returns {carry, data}.
  function automatic logic [W:0] step_fn(input logic [W-1:0] d,
                                         input logic [2:0]   op,
                                         input logic [AW-1:0] s);
    logic [W-1:0] r;
    logic         c;
    logic [W-1:0] lo_t;
    logic [W-1:0] hi_t;
    lo_t = d >> (s - AW'(1));
    hi_t = d >> (W - int'(s));
    r    = d;
    c    = 1'b0;
    case (op)
      OP_LSL: begin
        r = d << s;
        c = hi_t[0];
      end
      OP_LSR: begin
        r = d >> s;
        c = lo_t[0];
      end
      OP_ASR: begin
        r = $signed(d) >>> s;
        c = lo_t[0];
      end
      OP_ROR: begin
        r = (d >> s) | (d << (W - int'(s)));
        c = lo_t[0];
      end
      default: begin
        r = d;
        c = 1'b0;
      end
    endcase
    return {c, r};
  endfunction

  always_comb begin
    // Only reachable for non-power-of-two W.
    amt_sat     = (in_amt > AMT_MAX) ? AMT_MAX : in_amt;
    is_shift_op = (in_op >= OP_LSL) && (in_op <= OP_ROR);
    s_step      = (rem_q < STEP_A) ? rem_q : STEP_A;
    step_res    = step_fn(data_q, op_q, s_step);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          op_d    = in_op;
          carry_d = 1'b0;
          if ((amt_sat == '0) || !is_shift_op) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            rem_d   = amt_sat;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d  = step_res[W-1:0];
        carry_d = step_res[W];
        rem_d   = rem_q - s_step;
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything; the visible data/carry keep their last value.
    if (clear) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      data_d  = data_q;
      carry_d = carry_q;
      op_d    = op_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_zero  = (data_q == '0);

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter (W=16, STEP=4): directed operations checked against a
// whole-amount arithmetic model, plus backpressure, abort and async reset cases.
module tb_seq_shifter;
  localparam int W    = 16;
  localparam int STEP = 4;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [2:0]    in_op;
  logic [AW-1:0] in_amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;

  int n_vec = 0;
  int n_err = 0;

  logic         exp_on = 1'b0;
  logic [W-1:0] exp_data;
  logic         exp_carry;

  seq_shifter #(.W(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result of shifting by the whole amount at once; carry is the last bit to leave.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [2:0] op, input int amt);
    logic [W-1:0] r;
    logic [W-1:0] t;
    logic         c;
    r = d;
    c = 1'b0;
    if (amt != 0) begin
      case (op)
        3'd1: begin r = d << amt; t = d >> (W - amt); c = t[0]; end
        3'd2: begin r = d >> amt; t = d >> (amt - 1); c = t[0]; end
        3'd3: begin r = $signed(d) >>> amt; t = d >> (amt - 1); c = t[0]; end
        3'd4: begin r = (d >> amt) | (d << (W - amt)); t = d >> (amt - 1); c = t[0]; end
        default: begin r = d; c = 1'b0; end
      endcase
    end
    return {c, r};
  endfunction

  // Output check on every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_on) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_data));
        chk("out_carry", 32'(out_carry), 32'(exp_carry));
        chk("out_zero", 32'(out_zero), 32'(exp_data == '0));
      end
    end
  end

  task automatic do_op(input logic [W-1:0] d, input logic [2:0] op, input int amt, input int hold);
    int exp_lat;
    int cnt;
    {exp_carry, exp_data} = model(d, op, amt);
    exp_lat = (op >= 3'd1 && op <= 3'd4 && amt != 0) ? (amt + STEP - 1) / STEP : 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_op     = op;
    in_amt    = AW'(amt);
    out_ready = 1'b0;
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_on   = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      in_op    = 3'd1;
      in_amt   = 4'd3;
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_on    = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_amt    = '0;
    out_ready = 1'b0;

    // Model pinned to hand-worked values.
    chk("model_lsl", 32'(model(16'h0001, 3'd1, 5)), 32'h00020);
    chk("model_asr", 32'(model(16'h8000, 3'd3, 15)), 32'h0FFFF);
    chk("model_lsr", 32'(model(16'h8000, 3'd2, 15)), 32'h00001);
    chk("model_ror", 32'(model(16'h0001, 3'd4, 1)), 32'h18000);
    chk("model_lsr_zero", 32'(model(16'h0008, 3'd2, 4)), 32'h10000);
    chk("model_pass", 32'(model(16'hBEEF, 3'd7, 7)), 32'h0BEEF);
    chk("model_ror8", 32'(model(16'h1234, 3'd4, 8)), 32'h03412);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h0001, 3'd1, 5, 0);
    do_op(16'h8000, 3'd3, 15, 0);
    do_op(16'h8000, 3'd2, 15, 0);
    do_op(16'h0001, 3'd4, 1, 0);
    do_op(16'h0008, 3'd2, 4, 0);
    do_op(16'hBEEF, 3'd1, 0, 0);
    do_op(16'hBEEF, 3'd7, 7, 0);
    do_op(16'h8421, 3'd3, 6, 0);
    do_op(16'hF00F, 3'd1, 13, 0);
    do_op(16'hA5C3, 3'd4, 11, 0);
    do_op(16'h1234, 3'd4, 8, 10);

    // Abort mid-SHIFT: LSL 0xFFFF by 15, clear on the second shift edge.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF; in_op = 3'd1; in_amt = 4'd15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_in_ready", 32'(in_ready), 32'd1);
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    chk("clear_out_data", 32'(out_data), 32'h0000FFF0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("clear_no_valid", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-SHIFT, sampled with no clock edge in between.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF; in_op = 3'd1; in_amt = 4'd15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_carry", 32'(out_carry), 32'd0);
    chk("arst_out_zero", 32'(out_zero), 32'd1);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    do_op(16'h00F0, 3'd2, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle successor to the datapath combinational shifter.
- Shifts or rotates a W-bit operand by a runtime amount, moving at most STEP bit positions per clock.
- Uses ready/valid handshakes on input and output, and reports carry-out and zero flags.
- Sits between the register-file read stage and the ALU for multi-bit shift instructions.

Parameters:
- W, 16: operand width in bits; must be ≥ 2.
- STEP, 4: maximum bit positions shifted per cycle; 1 ≤ STEP ≤ W-1.
- AW, $clog2(W): width of the shift-amount field (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE and drops any in-flight operation.
- in_valid  in  1  input operand, op and amount are valid.
- in_ready  out  1  block can accept an operation.
- in_data  in  W  operand.
- in_op  in  3  000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROR; 101–111 treated as pass.
- in_amt  in  AW  shift amount, 0..W-1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  W  shifted result.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_data == 0.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; in_ready = 1; out_valid = 0; out_data = 0; out_carry = 0; out_zero = 1.
  - Internal remaining-count and op registers are cleared to 0.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready: latch in_data, in_op and in_amt; set carry = 0.
  - If in_amt == 0 or op is pass: go to DONE; data is unchanged, carry = 0.
  - Otherwise go to SHIFT with remaining = in_amt.
- SHIFT, every edge:
  - s = min(STEP, remaining); shift the data register by s; remaining -= s.
  - When remaining becomes 0, go to DONE.
- Step rules, for a step of size s:
  - LSL: fill with 0; carry = data[W-s].
  - LSR: fill with 0; carry = data[s-1].
  - ASR: fill with data[W-1]; carry = data[s-1].
  - ROR: data = {data[s-1:0], data[W-1:s]}; carry = data[s-1].
- Latency: counting the accepting edge as edge 1, out_valid asserts after edge 1 + ceil(in_amt/STEP). Amount 0 gives out_valid after edge 1.
- DONE:
  - out_data, out_carry and out_zero are stable while out_valid && !out_ready (full backpressure hold).
  - On out_ready: go to IDLE.
  - No same-cycle accept from DONE; the earliest next accept is the cycle after the handshake.
- Flags: out_zero is combinational from the data register. out_carry is registered and updates only on SHIFT steps and on accept.
- clear has priority over all transitions: next state is IDLE, remaining = 0, out_valid deasserts next cycle, and any result is discarded. out_data retains its last value.
- in_valid while busy is ignored (in_ready = 0); the upstream stage holds its request.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; no partial result is emitted.
- Amounts ≥ W cannot occur (AW bits, with W a power of two). For non-power-of-two W, the amount saturates to W-1.
- The result is identical for any legal STEP; only latency differs.

Test Plan (W=16, STEP=4):
- LSL 0x0001 amt 5 → out_data 0x0020, carry 0, zero 0; out_valid after edge 3 (ceil(5/4) = 2 steps).
- ASR 0x8000 amt 15 → 0xFFFF, carry 0, out_valid after edge 5. LSR 0x8000 amt 15 → 0x0001, carry 0.
- ROR 0x0001 amt 1 → 0x8000, carry 1, latency 1 step. LSR 0x0008 amt 4 → 0x0000, carry 1, zero 1.
- amt 0, op LSL, data 0xBEEF → 0xBEEF, carry 0, out_valid after edge 1. Op 111 with amt 7 → pass-through, same timing.
- Backpressure: hold out_ready = 0 for 10 cycles → out_data, out_carry and out_valid stable and in_ready = 0 throughout. Release → one handshake, then in_ready = 1 on the next cycle.
- Abort: assert clear mid-SHIFT on LSL 0xFFFF amt 15 → IDLE next cycle with no out_valid pulse. Separately, drop rst_n asynchronously mid-SHIFT → outputs at reset values with no clock edge; a subsequent operation completes correctly.
